// File: rtl/stage_ex_muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The EX stage is the master; the unit is the slave.
interface stage_ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       operator;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] hi_i;
    logic [WIDTH-1:0] lo_i;
    logic             cancel;
    logic             busy;
    logic             register_hi_write_enable;
    logic [WIDTH-1:0] register_hi_write_data;
    logic             register_lo_write_enable;
    logic [WIDTH-1:0] register_lo_write_data;

    modport master (
        output start, operator, operand_a, operand_b, hi_i, lo_i, cancel,
        input  busy, register_hi_write_enable, register_hi_write_data,
               register_lo_write_enable, register_lo_write_data
    );

    modport slave (
        input  start, operator, operand_a, operand_b, hi_i, lo_i, cancel,
        output busy, register_hi_write_enable, register_hi_write_data,
               register_lo_write_enable, register_lo_write_data
    );
endinterface

// File: rtl/stage_ex_muldiv.sv
// Multi-cycle multiply / multiply-accumulate / restoring-divide unit writing HI/LO.
// Raises busy as a stall request and emits a one-cycle HI/LO write pulse on completion.
module stage_ex_muldiv #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input logic              clock,
    input logic              reset,
    stage_ex_muldiv_if.slave bus
);
    localparam int CNT_MAX = (WIDTH + 1 > MUL_CYCLES) ? WIDTH + 1 : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, next_state;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, hi_acc_q, lo_acc_q;
    logic [WIDTH-1:0] quot_q, rem_q, div_mag_q;
    logic             neg_quot_q, neg_rem_q;
    logic [CNT_W-1:0] cnt_q;

    logic             busy_q, write_q, busy_d, write_d;
    logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d, fin_hi, fin_lo;

    logic             issue, in_signed, in_div;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign issue     = bus.start && !bus.cancel;
    assign in_signed = !bus.operator[0];
    assign in_div    = (bus.operator[2:1] == 2'b01);
    assign a_mag     = (in_signed && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
    assign b_mag     = (in_signed && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;

    // Operands are widened to 2*WIDTH so the truncated product is exact for both signednesses.
    logic               q_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, acc, mul_result;
    logic [WIDTH-1:0]   b_raw_q;

    assign q_signed = !op_q[0];
    assign ext_a    = q_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b    = q_signed ? {{WIDTH{b_raw_q[WIDTH-1]}}, b_raw_q} : {{WIDTH{1'b0}}, b_raw_q};
    assign product  = ext_a * ext_b;
    assign acc      = {hi_acc_q, lo_acc_q};

    always_comb begin
        case (op_q[2:1])
            2'b10:   mul_result = acc + product;
            2'b11:   mul_result = acc - product;
            default: mul_result = product;
        endcase
    end

    logic [WIDTH:0] rem_shift, rem_diff;
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, div_mag_q};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            write_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state   <= next_state;
            busy_q  <= busy_d;
            write_q <= write_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        next_state = state;
        fin_hi     = '0;
        fin_lo     = '0;
        case (state)
            IDLE: if (issue) next_state = in_div ? DIV : MUL;
            MUL: begin
                if (bus.cancel) begin
                    next_state = IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    next_state = DONE;
                    fin_hi     = mul_result[2*WIDTH-1:WIDTH];
                    fin_lo     = mul_result[WIDTH-1:0];
                end
            end
            DIV: begin
                if (bus.cancel) begin
                    next_state = IDLE;
                end else if (div_mag_q == '0) begin
                    next_state = DONE;
                    fin_hi     = a_q;
                    fin_lo     = '1;
                end else if (cnt_q == DIV_LAST) begin
                    next_state = DONE;
                    fin_hi     = neg_rem_q  ? -rem_q  : rem_q;
                    fin_lo     = neg_quot_q ? -quot_q : quot_q;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (next_state == MUL) || (next_state == DIV);
        write_d = (next_state == DONE);
        hi_d    = write_d ? fin_hi : '0;
        lo_d    = write_d ? fin_lo : '0;
    end

    // One restoring step per DIV cycle until the counter reaches the sign-correction slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q       <= '0;
            a_q        <= '0;
            b_raw_q    <= '0;
            hi_acc_q   <= '0;
            lo_acc_q   <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_mag_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    op_q       <= bus.operator;
                    a_q        <= bus.operand_a;
                    b_raw_q    <= bus.operand_b;
                    hi_acc_q   <= bus.hi_i;
                    lo_acc_q   <= bus.lo_i;
                    quot_q     <= a_mag;
                    rem_q      <= '0;
                    div_mag_q  <= b_mag;
                    neg_quot_q <= in_signed && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                    neg_rem_q  <= in_signed && bus.operand_a[WIDTH-1];
                    cnt_q      <= '0;
                end
                MUL: cnt_q <= cnt_q + 1'b1;
                DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q != DIV_LAST) begin
                        if (!rem_diff[WIDTH]) begin
                            rem_q  <= rem_diff[WIDTH-1:0];
                            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_q  <= rem_shift[WIDTH-1:0];
                            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy                     = busy_q;
    assign bus.register_hi_write_enable = write_q;
    assign bus.register_lo_write_enable = write_q;
    assign bus.register_hi_write_data   = hi_q;
    assign bus.register_lo_write_data   = lo_q;
endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Bench for stage_ex_muldiv: directed operations with literal expectations, plus an
// arithmetic reference model compared against the unit's outputs every cycle.
module tb_stage_ex_muldiv;
    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic compare_en = 1'b0;

    stage_ex_muldiv_if #(.WIDTH(WIDTH)) bus ();

    stage_ex_muldiv #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Reference arithmetic straight from the operator definitions, done in 64-bit integers.
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] hi,
                                                 input logic [31:0] lo);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] sprod = sa * sb;
        logic [63:0] uprod = {32'h0, a} * {32'h0, b};
        logic [63:0] accv = {hi, lo};
        logic [63:0] qv;
        logic [63:0] rv;
        case (op)
            3'd0: return sprod;
            3'd1: return uprod;
            3'd4: return accv + sprod;
            3'd5: return accv + uprod;
            3'd6: return accv - sprod;
            3'd7: return accv - uprod;
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (op == 3'd3) return {a % b, a / b};
                qv = sa / sb;
                rv = sa % sb;
                return {rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'd2 || op == 3'd3) return (b == 32'h0) ? 1 : WIDTH + 1;
        return MUL_CYCLES;
    endfunction

    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_result = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_we   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_we) begin
            m_we <= 1'b0;
            m_hi <= '0;
            m_lo <= '0;
        end else if (m_left != 0) begin
            if (bus.cancel) begin
                m_left <= 0;
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_left <= 0;
                m_busy <= 1'b0;
                m_we   <= 1'b1;
                m_hi   <= m_result[63:32];
                m_lo   <= m_result[31:0];
            end else begin
                m_left <= m_left - 1;
            end
        end else if (bus.start && !bus.cancel) begin
            m_result <= model_result(bus.operator, bus.operand_a, bus.operand_b, bus.hi_i, bus.lo_i);
            m_left   <= model_latency(bus.operator, bus.operand_b);
            m_busy   <= 1'b1;
        end
    end

    always @(negedge clock) begin
        if (compare_en) begin
            check_output("cmp_busy", 64'(bus.busy), 64'(m_busy));
            check_output("cmp_hi_we", 64'(bus.register_hi_write_enable), 64'(m_we));
            check_output("cmp_lo_we", 64'(bus.register_lo_write_enable), 64'(m_we));
            check_output("cmp_hi_data", 64'(bus.register_hi_write_data), 64'(m_hi));
            check_output("cmp_lo_data", 64'(bus.register_lo_write_data), 64'(m_lo));
        end
    end

    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo);
        bus.start     = 1'b1;
        bus.operator  = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.hi_i      = hi;
        bus.lo_i      = lo;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic await_result(input string name, input int exp_cycles,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_cycles = 0;
        int guard = 0;
        while (!bus.register_hi_write_enable && guard < 200) begin
            if (bus.busy) busy_cycles++;
            @(negedge clock);
            guard++;
        end
        check_output({name, "_done"}, 64'(guard < 200), 64'd1);
        check_output({name, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_cycles));
        check_output({name, "_hi"}, 64'(bus.register_hi_write_data), 64'(exp_hi));
        check_output({name, "_lo"}, 64'(bus.register_lo_write_data), 64'(exp_lo));
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        apply_stimulus(op, a, b, hi, lo);
        await_result(name, exp_cycles, exp_hi, exp_lo);
        @(negedge clock);
    endtask

    initial begin
        int pulses;
        bus.start     = 1'b0;
        bus.cancel    = 1'b0;
        bus.operator  = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.hi_i      = '0;
        bus.lo_i      = '0;
        repeat (3) @(negedge clock);
        check_output("reset_busy", 64'(bus.busy), 64'd0);
        check_output("reset_we", 64'(bus.register_hi_write_enable | bus.register_lo_write_enable), 64'd0);
        check_output("reset_data", {bus.register_hi_write_data, bus.register_lo_write_data}, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        compare_en = 1'b1;

        run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, '0, '0, 2, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 2, 32'hFFFFFFFE, 32'h00000001);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, '0, '0, 33, 32'h2, 32'hE);
        run_op("divu_max_1", 3'd3, 32'hFFFFFFFF, 32'd1, '0, '0, 33, 32'h0, 32'hFFFFFFFF);
        run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, '0, '0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFFFFFE, '0, '0, 33, 32'h1, 32'hFFFFFFFD);
        run_op("div_min_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF, '0, '0, 33, 32'h0, 32'h80000000);
        run_op("div_by_zero", 3'd2, 32'h1234, 32'd0, '0, '0, 1, 32'h1234, 32'hFFFFFFFF);
        run_op("divu_by_zero", 3'd3, 32'h10, 32'd0, '0, '0, 1, 32'h10, 32'hFFFFFFFF);
        run_op("maddu_carry", 3'd5, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 2, 32'h1, 32'h0);
        run_op("madd_neg", 3'd4, 32'hFFFFFFFE, 32'd3, 32'h0, 32'd10, 2, 32'h0, 32'h4);
        run_op("msub_wrap", 3'd6, 32'd1, 32'd1, 32'h0, 32'h0, 2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("msubu_borrow", 3'd7, 32'd2, 32'd3, 32'h1, 32'h0, 2, 32'h0, 32'hFFFFFFFA);

        apply_stimulus(3'd3, 32'd100, 32'd7, '0, '0);
        repeat (9) @(negedge clock);
        bus.cancel = 1'b1;
        @(negedge clock);
        bus.cancel = 1'b0;
        check_output("cancel_busy", 64'(bus.busy), 64'd0);
        pulses = 0;
        repeat (40) begin
            if (bus.register_hi_write_enable || bus.register_lo_write_enable) pulses++;
            @(negedge clock);
        end
        check_output("cancel_no_pulse", 64'(pulses), 64'd0);

        apply_stimulus(3'd3, 32'd100, 32'd7, '0, '0);
        repeat (4) @(negedge clock);
        apply_stimulus(3'd0, 32'd3, 32'd3, '0, '0);
        await_result("start_while_busy", 28, 32'h2, 32'hE);
        bus.start     = 1'b1;
        bus.operator  = 3'd0;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd9;
        @(negedge clock);
        bus.start = 1'b0;
        check_output("start_in_done_ignored", 64'(bus.busy), 64'd0);

        bus.start    = 1'b1;
        bus.cancel   = 1'b1;
        bus.operator = 3'd3;
        @(negedge clock);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check_output("start_cancel_idle", 64'(bus.busy), 64'd0);

        apply_stimulus(3'd3, 32'd100, 32'd7, '0, '0);
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_output("reset_mid_busy", 64'(bus.busy), 64'd0);
        check_output("reset_mid_we", 64'(bus.register_hi_write_enable | bus.register_lo_write_enable), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_output("reset_release_idle", 64'(bus.busy), 64'd0);

        run_op("after_reset_mult", 3'd0, 32'd6, 32'd7, '0, '0, 2, 32'h0, 32'd42);

        compare_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
